svc_rv_mem_arb: RTL
===================

// Module: svc_rv_mem_arb
//
// PURPOSE
// - Shares one single-ported synchronous memory between the RV core's fetch port (I) and load/store port (D).
// - Lets the core run from a unified code+data RAM.
// - Sits between svc_rv (fetch address from the PC, D-port from the ALU result) and the RAM.
// - Grants one access per cycle. Routes read data back to its owner. Stops D traffic from starving fetch.
//
// PARAMETERS
// - XLEN          32  data/address width of both requester ports
// - AW            10  memory word-address width; byte address bits [AW+1:2] are used
// - MAX_D_STREAK   4  consecutive D grants allowed while I is waiting; range 1..15
//
// PORTS
// - clk          in   1        the only clock
// - rst          in   1        reset; synchronous, active-high
// - i_req_valid  in   1        fetch request
// - i_req_ready  out  1        fetch request accepted this cycle
// - i_req_addr   in   XLEN     fetch byte address
// - i_rd_valid   out  1        fetch data valid
// - i_rd_data    out  XLEN     fetch data
// - d_req_valid  in   1        load/store request
// - d_req_ready  out  1        load/store request accepted this cycle
// - d_req_addr   in   XLEN     load/store byte address
// - d_req_write  in   1        1 = store, 0 = load
// - d_req_wdata  in   XLEN     store data
// - d_req_wstrb  in   XLEN/8   store byte enables
// - d_rd_valid   out  1        load data valid
// - d_rd_data    out  XLEN     load data
// - mem_en       out  1        memory access strobe
// - mem_we       out  1        memory write enable
// - mem_addr     out  AW       memory word address
// - mem_wdata    out  XLEN     memory write data
// - mem_wstrb    out  XLEN/8   memory byte enables
// - mem_rdata    in   XLEN     memory read data; valid the cycle after a read strobe
//
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high.
// - Handshake: a request is accepted when valid && ready. ready is combinational from the valids and the streak state.
//   - At most one of i_req_ready / d_req_ready is high per cycle.
//   - Neither ready is high unless its own valid is high.
// - Arbitration:
//   - D has priority: it belongs to the older in-flight instruction.
//   - Exception: when streak == MAX_D_STREAK and i_req_valid is high, I wins.
//   - streak counts consecutive D grants made while i_req_valid was high.
//   - streak resets to 0 on any I grant, or on any cycle with i_req_valid low. It saturates at MAX_D_STREAK.
// - Memory drive:
//   - mem_en = any grant.
//   - mem_we = D grant && d_req_write.
//   - mem_addr = granted addr[AW+1:2]. Address bits [1:0] and above AW+1 are ignored.
//   - On an I grant: mem_wstrb = 0 and mem_wdata = 0.
// - Read return:
//   - Latency is exactly 1 cycle; throughput is 1 read per cycle.
//   - An owner register (RD_NONE / RD_I / RD_D) captures each granted read.
//   - Next cycle: i_rd_valid or d_rd_valid pulses for 1 cycle, with *_rd_data = mem_rdata.
//   - Stores produce no response; the owner register is RD_NONE after a store.
//   - There is no response backpressure: requesters must sink data on the valid cycle.
//   - Inactive *_rd_data is 0, not mem_rdata.
// - Simultaneous events: I and D both valid with streak < MAX -> D granted, I waits with ready low. Its request stays pending, not lost.
// - Reset values:
//   - All ready and rd_valid outputs 0.
//   - mem_en 0, mem_we 0.
//   - mem_addr, mem_wdata, mem_wstrb 0.
//   - streak 0, owner RD_NONE.
// - Reset mid-operation: a read granted the cycle before rst produces no rd_valid. Owner is cleared. No grants while rst is high.
//
// STRUCTURE
// - svc_rv_mem_pkg holds:
//   - typedef enum logic [1:0] {RD_NONE, RD_I, RD_D} mem_owner_t
//   - STREAK_W = 4
// - One sub-module, svc_rv_arb_streak: the saturating streak counter. It produces force_i.
// - Grant logic, the mem drive mux and the owner register are inline.
//
// TESTING
// - I only, addrs 0x0,0x4,0x8 back-to-back -> mem_addr 0,1,2 on consecutive cycles; i_rd_valid on cycles +1..+3 with mem_rdata.
// - I and D both valid, D load @0x40 -> d_req_ready=1, i_req_ready=0, mem_addr=0x10; d_rd_valid next cycle; I granted the following cycle.
// - D and I valid continuously, MAX_D_STREAK=4 -> grant pattern D,D,D,D,I repeating; no cycle with both readys high.
// - D store, wstrb=4'b0011, wdata=0xDEADBEEF @0x8 -> mem_we=1, mem_addr=2, mem_wstrb=0011; no d_rd_valid the next cycle.
// - Load granted, rst asserted the next cycle -> d_rd_valid stays 0; all outputs 0 during rst; normal operation resumes on deassert.
// - Random I/D valid traffic over 10k cycles -> every read returns to its own owner; I waits at most MAX_D_STREAK cycles.

Source files
------------

// File: rtl/svc_rv_mem_pkg.sv
// Shared types for the RV core memory arbiter.
// Read-owner encoding and streak counter width.
package svc_rv_mem_pkg;

    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_I    = 2'd1,
        RD_D    = 2'd2
    } mem_owner_t;

endpackage

// File: rtl/svc_rv_arb_streak.sv
// Saturating count of D grants made while a fetch waits.
// Raises force_i once fetch has been held off long enough.
module svc_rv_arb_streak
    import svc_rv_mem_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req_valid,
    input  logic i_grant,
    input  logic d_grant,
    output logic force_i
);

    localparam logic [STREAK_W-1:0] MAX = STREAK_W'(MAX_D_STREAK);

    logic [STREAK_W-1:0] streak;

    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (!i_req_valid || i_grant) begin
            streak <= '0;
        end else if (d_grant && (streak != MAX)) begin
            streak <= streak + 1'b1;
        end
    end

    assign force_i = i_req_valid && (streak == MAX);

endmodule

// File: rtl/svc_rv_mem_arb.sv
// Shares one single-ported synchronous RAM between fetch (I)
// and load/store (D); D wins unless fetch has starved too long.
module svc_rv_mem_arb
    import svc_rv_mem_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int AW           = 10,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [XLEN-1:0]   i_req_addr,
    output logic              i_rd_valid,
    output logic [XLEN-1:0]   i_rd_data,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [XLEN-1:0]   d_req_addr,
    input  logic              d_req_write,
    input  logic [XLEN-1:0]   d_req_wdata,
    input  logic [XLEN/8-1:0] d_req_wstrb,
    output logic              d_rd_valid,
    output logic [XLEN-1:0]   d_rd_data,

    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic [XLEN-1:0]   mem_rdata
);

    logic       force_i;
    logic       i_grant;
    logic       d_grant;
    mem_owner_t owner;

    svc_rv_arb_streak #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_streak (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .i_grant     (i_grant),
        .d_grant     (d_grant),
        .force_i     (force_i)
    );

    // force_i already implies i_req_valid
    assign d_grant = !rst && d_req_valid && !force_i;
    assign i_grant = !rst && i_req_valid && (!d_req_valid || force_i);

    assign i_req_ready = i_grant;
    assign d_req_ready = d_grant;

    always_comb begin
        mem_en    = i_grant || d_grant;
        mem_we    = d_grant && d_req_write;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        unique case (1'b1)
            d_grant: begin
                mem_addr = d_req_addr[AW+1:2];
                if (d_req_write) begin
                    mem_wdata = d_req_wdata;
                    mem_wstrb = d_req_wstrb;
                end
            end
            i_grant: begin
                mem_addr = i_req_addr[AW+1:2];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= RD_NONE;
        end else if (i_grant) begin
            owner <= RD_I;
        end else if (d_grant && !d_req_write) begin
            owner <= RD_D;
        end else begin
            owner <= RD_NONE;
        end
    end

    // A read caught by reset must not surface
    assign i_rd_valid = !rst && (owner == RD_I);
    assign d_rd_valid = !rst && (owner == RD_D);
    assign i_rd_data  = i_rd_valid ? mem_rdata : '0;
    assign d_rd_data  = d_rd_valid ? mem_rdata : '0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_req_addr[XLEN-1:AW+2], i_req_addr[1:0],
                                d_req_addr[XLEN-1:AW+2], d_req_addr[1:0]};

endmodule
